// File: rtl/fp_accum_ctrl_if.sv
// rtl/fp_accum_ctrl_if.sv - element stream, adder and sum handshake bundle for fp_accum_ctrl
interface fp_accum_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] length;
  logic [31:0]      in_data;
  logic             in_stb;
  logic             in_ack;
  logic [31:0]      add_a;
  logic             add_a_stb;
  logic             add_a_ack;
  logic [31:0]      add_b;
  logic             add_b_stb;
  logic             add_b_ack;
  logic [31:0]      add_z;
  logic             add_z_stb;
  logic             add_z_ack;
  logic [31:0]      sum_out;
  logic             sum_stb;
  logic             sum_ack;
  logic             busy;

  // Controller side
  modport master (
    input  start, length, in_data, in_stb, add_a_ack, add_b_ack, add_z, add_z_stb, sum_ack,
    output in_ack, add_a, add_a_stb, add_b, add_b_stb, add_z_ack, sum_out, sum_stb, busy
  );

  // Environment side: element source, adder and sum consumer
  modport slave (
    output start, length, in_data, in_stb, add_a_ack, add_b_ack, add_z, add_z_stb, sum_ack,
    input  in_ack, add_a, add_a_stb, add_b, add_b_stb, add_z_ack, sum_out, sum_stb, busy
  );
endinterface

// File: rtl/fp_accum_ctrl.sv
// rtl/fp_accum_ctrl.sv - sequencer summing a float stream through the shared stb/ack adder
module fp_accum_ctrl #(
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  fp_accum_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_X   = 3'd1,
    SEND_A  = 3'd2,
    SEND_B  = 3'd3,
    WAIT_Z  = 3'd4,
    PUT_SUM = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      acc;
  logic [31:0]      x;

  logic start_go;
  logic in_xfer;
  logic a_xfer;
  logic b_xfer;
  logic z_xfer;
  logic s_xfer;
  logic last;

  logic in_ack_d;
  logic add_a_stb_d;
  logic add_b_stb_d;
  logic add_z_ack_d;
  logic sum_stb_d;

  assign start_go = (state == IDLE) && bus.start;
  assign in_xfer  = bus.in_stb & bus.in_ack;
  assign a_xfer   = bus.add_a_stb & bus.add_a_ack;
  assign b_xfer   = bus.add_b_stb & bus.add_b_ack;
  assign z_xfer   = bus.add_z_stb & bus.add_z_ack;
  assign s_xfer   = bus.sum_stb & bus.sum_ack;
  assign cnt_inc  = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  // cnt_inc cannot overflow: cnt stops at len, which is at most 2**CNT_W-1
  assign last     = (cnt_inc == len);
  assign bus.busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: advance only on the edge where the current state's transfer completes
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = (bus.length == '0) ? PUT_SUM : GET_X;
      GET_X:   if (in_xfer)   next_state = SEND_A;
      SEND_A:  if (a_xfer)    next_state = SEND_B;
      SEND_B:  if (b_xfer)    next_state = WAIT_Z;
      WAIT_Z:  if (z_xfer)    next_state = last ? PUT_SUM : GET_X;
      PUT_SUM: if (s_xfer)    next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Handshake outputs: raised the cycle after entering their state, dropped after the transfer edge
  always_comb begin
    in_ack_d    = (state == GET_X)   && !in_xfer;
    add_a_stb_d = (state == SEND_A)  && !a_xfer;
    add_b_stb_d = (state == SEND_B)  && !b_xfer;
    add_z_ack_d = (state == WAIT_Z)  && !z_xfer;
    sum_stb_d   = (state == PUT_SUM) && !s_xfer;
  end

  // Handshake output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ack    <= 1'b0;
      bus.add_a_stb <= 1'b0;
      bus.add_b_stb <= 1'b0;
      bus.add_z_ack <= 1'b0;
      bus.sum_stb   <= 1'b0;
    end else begin
      bus.in_ack    <= in_ack_d;
      bus.add_a_stb <= add_a_stb_d;
      bus.add_b_stb <= add_b_stb_d;
      bus.add_z_ack <= add_z_ack_d;
      bus.sum_stb   <= sum_stb_d;
    end
  end

  // Datapath: length/count, accumulator, and operand/result registers held stable while strobed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len         <= '0;
      cnt         <= '0;
      acc         <= 32'h0000_0000;
      x           <= 32'h0000_0000;
      bus.add_a   <= 32'h0000_0000;
      bus.add_b   <= 32'h0000_0000;
      bus.sum_out <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (start_go) begin
            len <= bus.length;
            cnt <= '0;
            acc <= 32'h0000_0000;
          end
        end
        GET_X:   if (in_xfer) x <= bus.in_data;
        SEND_A:  if (!bus.add_a_stb) bus.add_a <= acc;
        SEND_B:  if (!bus.add_b_stb) bus.add_b <= x;
        WAIT_Z: begin
          if (z_xfer) begin
            acc <= bus.add_z;
            cnt <= cnt_inc;
          end
        end
        PUT_SUM: if (!bus.sum_stb) bus.sum_out <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// tb/tb_fp_accum_ctrl.sv - scoreboard bench for fp_accum_ctrl with a behavioural adder
module tb_fp_accum_ctrl;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_accum_ctrl_if #(.CNT_W(CNT_W)) bus();
  fp_accum_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  typedef struct {
    logic [31:0] sum;
    int          n;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [31:0] src_q[$];
  int          src_gap_cfg = -1;
  int          sink_delay_cfg = -1;
  int          n_elems = 0;
  int          sums_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Integer-valued floats only (|v| < 2**24), which keeps every sum exact
  function automatic logic [31:0] i2f(input int v);
    logic        s;
    int          mag;
    int          p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    s   = (v < 0);
    mag = s ? -v : v;
    p   = 0;
    for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
    m = 32'(mag) << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int mag;
    if (f[30:0] == 31'h0) return 0;
    e   = int'(f[30:23]) - 127;
    mag = int'({1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'hFFC0_0000;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    return i2f(f2i(a) + f2i(b));
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobes"}, {26'b0, bus.in_ack, bus.add_a_stb, bus.add_b_stb,
                              bus.add_z_ack, bus.sum_stb, bus.busy}, 32'h0);
    check({tag, "_add_a"}, bus.add_a, 32'h0);
    check({tag, "_add_b"}, bus.add_b, 32'h0);
    check({tag, "_sum_out"}, bus.sum_out, 32'h0);
  endtask

  task automatic finish_up();
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Behavioural adder: accepts a then b, returns a+b after a random compute delay
  initial begin
    int phase, dly;
    logic [31:0] av, bv, zv, a_snap, b_snap;
    logic ax, bx, zx;
    phase = 0; dly = 0; av = 0; bv = 0; zv = 0; a_snap = 0; b_snap = 0;
    ax = 0; bx = 0; zx = 0;
    bus.add_a_ack = 0; bus.add_b_ack = 0; bus.add_z_stb = 0; bus.add_z = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; ax = 0; bx = 0; zx = 0;
        bus.add_a_ack = 0; bus.add_b_ack = 0; bus.add_z_stb = 0; bus.add_z = 0;
      end else begin
        if (ax) begin av = a_snap; phase = 1; end
        if (bx) begin bv = b_snap; zv = fadd(av, bv); dly = $urandom_range(0, 3); phase = 2; end
        if (zx) phase = 0;
        if (phase == 2) begin
          if (dly == 0) phase = 3;
          else dly--;
        end
        bus.add_a_ack = (phase == 0) && ($urandom_range(0, 3) != 0);
        bus.add_b_ack = (phase == 1) && ($urandom_range(0, 3) != 0);
        bus.add_z_stb = (phase == 3);
        bus.add_z     = (phase == 3) ? zv : $urandom;
        ax = bus.add_a_stb && bus.add_a_ack; a_snap = bus.add_a;
        bx = bus.add_b_stb && bus.add_b_ack; b_snap = bus.add_b;
        zx = bus.add_z_stb && bus.add_z_ack;
      end
    end
  end

  // Element source: presents queued elements with gaps, scrambles in_data while idle
  initial begin
    int   gap;
    logic ix;
    gap = 0; ix = 0;
    bus.in_stb = 0; bus.in_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        src_q.delete(); bus.in_stb = 0; ix = 0; gap = 0;
      end else begin
        if (ix) begin
          void'(src_q.pop_front());
          n_elems++;
          bus.in_stb = 0;
          gap = (src_gap_cfg < 0) ? $urandom_range(0, 2) : src_gap_cfg;
          ix = 0;
        end
        if (!bus.in_stb) begin
          if (gap > 0) begin
            gap--;
            bus.in_data = $urandom;
          end else if (src_q.size() > 0) begin
            bus.in_stb  = 1;
            bus.in_data = src_q[0];
          end else begin
            bus.in_data = $urandom;
          end
        end
        ix = bus.in_stb && bus.in_ack;
      end
    end
  end

  // Sum monitor: pops the scoreboard on each sum transfer and checks sum_out stays put while stalled
  initial begin
    logic        sx, holding;
    logic [31:0] held, s_snap;
    int          wait_cnt;
    exp_t        e;
    sx = 0; holding = 0; held = 0; s_snap = 0; wait_cnt = 0;
    bus.sum_ack = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.sum_ack = 0; sx = 0; holding = 0; n_elems = 0;
      end else begin
        if (sx) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_sum actual=%08h required=none", s_snap);
          end else begin
            e = sb.pop_front();
            check("sum_value", s_snap, e.sum);
            check("element_count", n_elems, e.n);
          end
          n_elems = 0; sums_done++; holding = 0; sx = 0;
        end
        if (bus.sum_stb) begin
          if (holding) check("sum_stable", bus.sum_out, held);
          else wait_cnt = (sink_delay_cfg < 0) ? $urandom_range(0, 3) : sink_delay_cfg;
          held = bus.sum_out; holding = 1;
          bus.sum_ack = (wait_cnt == 0);
          if (wait_cnt > 0) wait_cnt--;
        end else begin
          bus.sum_ack = 0; holding = 0;
        end
        sx = bus.sum_stb && bus.sum_ack; s_snap = bus.sum_out;
      end
    end
  end

  task automatic run_job(input logic [31:0] elems[$], input logic [31:0] exp_sum,
                         input int gap, input int ack_dly, input int extra_at);
    int   cyc, target, first_stb;
    logic quiet_bad;
    exp_t e;
    cyc = 0; first_stb = -1; quiet_bad = 0;
    while (bus.busy && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk); #2;
    src_gap_cfg = gap; sink_delay_cfg = ack_dly;
    foreach (elems[i]) src_q.push_back(elems[i]);
    e.sum = exp_sum; e.n = elems.size(); sb.push_back(e);
    target = sums_done + 1;
    bus.length = CNT_W'(elems.size());
    bus.start = 1;
    @(negedge clk); #2;
    bus.start = 0; bus.length = CNT_W'($urandom);
    check("busy_after_start", bus.busy, 1);
    cyc = 0;
    while (sums_done < target && cyc < 20000) begin
      @(negedge clk); #2; cyc++;
      if (bus.in_ack || bus.add_a_stb) quiet_bad = 1;
      if (bus.sum_stb && first_stb < 0) first_stb = cyc;
      if (cyc == extra_at) begin bus.start = 1; bus.length = CNT_W'($urandom); end
      else bus.start = 0;
    end
    bus.start = 0;
    if (sums_done < target) begin
      total++; bad++;
      $display("FAIL job_timeout actual=%0d sums required=%0d", sums_done, target);
      finish_up();
    end
    if (elems.size() == 0) begin
      check("zero_len_no_handshake", quiet_bad, 0);
      check("zero_len_latency_ok", first_stb >= 1 && first_stb <= 3, 1);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    int          s, v, n, cyc;
    exp_t        e;
    rst = 1; bus.start = 0; bus.length = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    #2 rst = 0;

    q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    run_job(q, 32'h40C0_0000, -1, -1, 0);

    q.delete();
    run_job(q, 32'h0000_0000, -1, 0, 0);

    q = '{i2f(7), i2f(-2)};
    run_job(q, i2f(5), 5, 10, 0);

    q = '{32'h7F80_0000, 32'hFF80_0000};
    run_job(q, 32'hFFC0_0000, -1, -1, 0);

    q = '{32'h8000_0000, 32'h8000_0000};
    run_job(q, 32'h0000_0000, -1, -1, 0);

    // Reset while the controller waits on the adder result
    @(negedge clk); #2;
    src_q.push_back(i2f(1)); src_q.push_back(i2f(2)); src_q.push_back(i2f(3));
    e.sum = i2f(6); e.n = 3; sb.push_back(e);
    bus.length = 3; bus.start = 1;
    @(negedge clk); #2 bus.start = 0;
    cyc = 0;
    while (!bus.add_z_ack && cyc < 200) begin @(negedge clk); #2; cyc++; end
    check("reached_wait_z", bus.add_z_ack, 1);
    rst = 1;
    sb.delete();
    @(posedge clk); #1;
    check_idle_outputs("midrun_reset");
    @(negedge clk); #2 rst = 0;
    q = '{32'h3F80_0000};
    run_job(q, 32'h3F80_0000, -1, -1, 0);

    for (int j = 0; j < 10; j++) begin
      q.delete();
      s = 0;
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) begin
        v = $urandom_range(0, 200) - 100;
        s += v;
        q.push_back(i2f(v));
      end
      run_job(q, i2f(s), -1, -1, 0);
    end

    q.delete();
    for (int k = 0; k < 255; k++) q.push_back(32'h3F80_0000);
    run_job(q, 32'h437F_0000, 0, -1, 100);

    repeat (5) @(negedge clk);
    check("final_idle", bus.busy, 0);
    finish_up();
  end
endmodule
